// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath defaults, ALU op codes,
// control-bundle bit positions and a WB->ID bypass helper.
package riscv_pkg;

    localparam int XLEN_DEFAULT    = 32;
    localparam int ALUOP_W_DEFAULT = 4;

    localparam logic [4:0] REG_X0 = 5'd0;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Control bundle bit positions
    localparam int CTRL_W          = 6;
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_BRANCH     = 5;

    // True when the WB write targets this source register; x0 never bypasses.
    function automatic logic bypass_hit(input logic       wb_we,
                                        input logic [4:0] wb_idx,
                                        input logic [4:0] rs_idx);
        return wb_we && (wb_idx != REG_X0) && (wb_idx == rs_idx);
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detector: flags a consumer instruction that
// reads the destination of a load still one stage ahead of it.
module load_use_detector
    import riscv_pkg::*;
(
    input  logic       consumer_valid,
    input  logic       consumer_uses_rs1,
    input  logic       consumer_uses_rs2,
    input  logic [4:0] consumer_rs1,
    input  logic [4:0] consumer_rs2,
    input  logic       producer_valid,
    input  logic       producer_mem_read,
    input  logic [4:0] producer_rd,
    output logic       hz
);

    logic rs1_match_s;
    logic rs2_match_s;

    // Hazard when a valid load writes a non-x0 register that the consumer reads.
    always_comb begin
        rs1_match_s = consumer_uses_rs1 && (producer_rd == consumer_rs1);
        rs2_match_s = consumer_uses_rs2 && (producer_rd == consumer_rs2);
        hz          = consumer_valid && producer_valid && producer_mem_read &&
                      (producer_rd != REG_X0) && (rs1_match_s || rs2_match_s);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion on hazard or
// flush, and WB->ID register-data bypass.
// Optional macro HAZARD_PERF_EN adds perf_stall_cnt / perf_flush_cnt outputs.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int ALUOP_W = ALUOP_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [4:0]         id_rd,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_ctrl_reg_write,
    input  logic               id_ctrl_mem_read,
    input  logic               id_ctrl_mem_write,
    input  logic               id_ctrl_mem_to_reg,
    input  logic               id_ctrl_alu_src,
    input  logic               id_ctrl_branch,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               ex_flush,
    input  logic               wb_reg_write,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               id_ex_valid,
    output logic [XLEN-1:0]    id_ex_pc,
    output logic [4:0]         id_ex_rs1,
    output logic [4:0]         id_ex_rs2,
    output logic               id_ex_uses_rs1,
    output logic               id_ex_uses_rs2,
    output logic [4:0]         id_ex_rd,
    output logic [XLEN-1:0]    id_ex_rs1_data,
    output logic [XLEN-1:0]    id_ex_rs2_data,
    output logic [XLEN-1:0]    id_ex_imm,
    output logic               id_ex_ctrl_reg_write,
    output logic               id_ex_ctrl_mem_read,
    output logic               id_ex_ctrl_mem_write,
    output logic               id_ex_ctrl_mem_to_reg,
    output logic               id_ex_ctrl_alu_src,
    output logic               id_ex_ctrl_branch,
    output logic [ALUOP_W-1:0] id_ex_alu_op,
`ifdef HAZARD_PERF_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    output logic               stall
);

    logic                hz_s;
    logic                capture_s;
    logic [CTRL_W-1:0]   ctrl_in_s;
    logic [XLEN-1:0]     rs1_byp_s;
    logic [XLEN-1:0]     rs2_byp_s;

    logic                valid_nxt_s;
    logic [XLEN-1:0]     pc_nxt_s;
    logic [4:0]          rs1_nxt_s;
    logic [4:0]          rs2_nxt_s;
    logic                uses_rs1_nxt_s;
    logic                uses_rs2_nxt_s;
    logic [4:0]          rd_nxt_s;
    logic [XLEN-1:0]     rs1_data_nxt_s;
    logic [XLEN-1:0]     rs2_data_nxt_s;
    logic [XLEN-1:0]     imm_nxt_s;
    logic [CTRL_W-1:0]   ctrl_nxt_s;
    logic [ALUOP_W-1:0]  alu_op_nxt_s;

    logic                valid_r;
    logic [XLEN-1:0]     pc_r;
    logic [4:0]          rs1_r;
    logic [4:0]          rs2_r;
    logic                uses_rs1_r;
    logic                uses_rs2_r;
    logic [4:0]          rd_r;
    logic [XLEN-1:0]     rs1_data_r;
    logic [XLEN-1:0]     rs2_data_r;
    logic [XLEN-1:0]     imm_r;
    logic [CTRL_W-1:0]   ctrl_r;
    logic [ALUOP_W-1:0]  alu_op_r;

    load_use_detector u_load_use_detector (
        .consumer_valid    (id_valid),
        .consumer_uses_rs1 (id_uses_rs1),
        .consumer_uses_rs2 (id_uses_rs2),
        .consumer_rs1      (id_rs1),
        .consumer_rs2      (id_rs2),
        .producer_valid    (valid_r),
        .producer_mem_read (ctrl_r[CTRL_MEM_READ]),
        .producer_rd       (rd_r),
        .hz                (hz_s)
    );

    // A flush redirects fetch, so it suppresses the stall request.
    assign stall = hz_s & ~ex_flush;

    // Next-state selection: bypass muxes, then capture or bubble.
    always_comb begin
        ctrl_in_s                  = {CTRL_W{1'b0}};
        ctrl_in_s[CTRL_REG_WRITE]  = id_ctrl_reg_write;
        ctrl_in_s[CTRL_MEM_READ]   = id_ctrl_mem_read;
        ctrl_in_s[CTRL_MEM_WRITE]  = id_ctrl_mem_write;
        ctrl_in_s[CTRL_MEM_TO_REG] = id_ctrl_mem_to_reg;
        ctrl_in_s[CTRL_ALU_SRC]    = id_ctrl_alu_src;
        ctrl_in_s[CTRL_BRANCH]     = id_ctrl_branch;

        if (bypass_hit(wb_reg_write, wb_rd, id_rs1)) begin
            rs1_byp_s = wb_data;
        end else begin
            rs1_byp_s = id_rs1_data;
        end
        if (bypass_hit(wb_reg_write, wb_rd, id_rs2)) begin
            rs2_byp_s = wb_data;
        end else begin
            rs2_byp_s = id_rs2_data;
        end

        // Flush beats hazard; both (and an empty decode) yield a zeroed bubble.
        capture_s = id_valid && !ex_flush && !hz_s;

        if (capture_s) begin
            valid_nxt_s    = 1'b1;
            pc_nxt_s       = id_pc;
            rs1_nxt_s      = id_rs1;
            rs2_nxt_s      = id_rs2;
            uses_rs1_nxt_s = id_uses_rs1;
            uses_rs2_nxt_s = id_uses_rs2;
            rd_nxt_s       = id_rd;
            rs1_data_nxt_s = rs1_byp_s;
            rs2_data_nxt_s = rs2_byp_s;
            imm_nxt_s      = id_imm;
            ctrl_nxt_s     = ctrl_in_s;
            alu_op_nxt_s   = id_alu_op;
        end else begin
            valid_nxt_s    = 1'b0;
            pc_nxt_s       = {XLEN{1'b0}};
            rs1_nxt_s      = 5'd0;
            rs2_nxt_s      = 5'd0;
            uses_rs1_nxt_s = 1'b0;
            uses_rs2_nxt_s = 1'b0;
            rd_nxt_s       = 5'd0;
            rs1_data_nxt_s = {XLEN{1'b0}};
            rs2_data_nxt_s = {XLEN{1'b0}};
            imm_nxt_s      = {XLEN{1'b0}};
            ctrl_nxt_s     = {CTRL_W{1'b0}};
            alu_op_nxt_s   = {ALUOP_W{1'b0}};
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            pc_r       <= {XLEN{1'b0}};
            rs1_r      <= 5'd0;
            rs2_r      <= 5'd0;
            uses_rs1_r <= 1'b0;
            uses_rs2_r <= 1'b0;
            rd_r       <= 5'd0;
            rs1_data_r <= {XLEN{1'b0}};
            rs2_data_r <= {XLEN{1'b0}};
            imm_r      <= {XLEN{1'b0}};
            ctrl_r     <= {CTRL_W{1'b0}};
            alu_op_r   <= {ALUOP_W{1'b0}};
        end else begin
            valid_r    <= valid_nxt_s;
            pc_r       <= pc_nxt_s;
            rs1_r      <= rs1_nxt_s;
            rs2_r      <= rs2_nxt_s;
            uses_rs1_r <= uses_rs1_nxt_s;
            uses_rs2_r <= uses_rs2_nxt_s;
            rd_r       <= rd_nxt_s;
            rs1_data_r <= rs1_data_nxt_s;
            rs2_data_r <= rs2_data_nxt_s;
            imm_r      <= imm_nxt_s;
            ctrl_r     <= ctrl_nxt_s;
            alu_op_r   <= alu_op_nxt_s;
        end
    end

    assign id_ex_valid           = valid_r;
    assign id_ex_pc              = pc_r;
    assign id_ex_rs1             = rs1_r;
    assign id_ex_rs2             = rs2_r;
    assign id_ex_uses_rs1        = uses_rs1_r;
    assign id_ex_uses_rs2        = uses_rs2_r;
    assign id_ex_rd              = rd_r;
    assign id_ex_rs1_data        = rs1_data_r;
    assign id_ex_rs2_data        = rs2_data_r;
    assign id_ex_imm             = imm_r;
    assign id_ex_ctrl_reg_write  = ctrl_r[CTRL_REG_WRITE];
    assign id_ex_ctrl_mem_read   = ctrl_r[CTRL_MEM_READ];
    assign id_ex_ctrl_mem_write  = ctrl_r[CTRL_MEM_WRITE];
    assign id_ex_ctrl_mem_to_reg = ctrl_r[CTRL_MEM_TO_REG];
    assign id_ex_ctrl_alu_src    = ctrl_r[CTRL_ALU_SRC];
    assign id_ex_ctrl_branch     = ctrl_r[CTRL_BRANCH];
    assign id_ex_alu_op          = alu_op_r;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt_r;
    logic [31:0] perf_flush_cnt_r;

    // Event counters for stall and flush cycles; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_r <= 32'd0;
            perf_flush_cnt_r <= 32'd0;
        end else begin
            if (stall) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
            end else begin
                perf_stall_cnt_r <= perf_stall_cnt_r;
            end
            if (ex_flush) begin
                perf_flush_cnt_r <= perf_flush_cnt_r + 32'd1;
            end else begin
                perf_flush_cnt_r <= perf_flush_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_flush_cnt = perf_flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a scoreboard queue holds the expected
// ID/EX register contents for each driven cycle, compared one edge later.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [5:0]  ctrl;   // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch}
        logic [3:0]  alu;
    } exp_t;

    localparam logic [5:0] C_LW  = 6'b110100;
    localparam logic [5:0] C_ADD = 6'b100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = 32'd0;
    logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic [31:0] id_rs1_data = 32'd0, id_rs2_data = 32'd0, id_imm = 32'd0;
    logic [5:0]  id_ctrl = 6'd0;
    logic [3:0]  id_alu_op = 4'd0;
    logic        ex_flush = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;

    logic        id_ex_valid, id_ex_uses_rs1, id_ex_uses_rs2;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic        c_rw, c_mr, c_mw, c_m2r, c_as, c_br;
    logic [3:0]  id_ex_alu_op;
    logic        stall;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mdl;       // bench model of the ID/EX register
    exp_t got;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl_reg_write(id_ctrl[5]), .id_ctrl_mem_read(id_ctrl[4]), .id_ctrl_mem_write(id_ctrl[3]),
        .id_ctrl_mem_to_reg(id_ctrl[2]), .id_ctrl_alu_src(id_ctrl[1]), .id_ctrl_branch(id_ctrl[0]),
        .id_alu_op(id_alu_op), .ex_flush(ex_flush), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs1(id_ex_rs1),
        .id_ex_rs2(id_ex_rs2), .id_ex_uses_rs1(id_ex_uses_rs1), .id_ex_uses_rs2(id_ex_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
        .id_ex_imm(id_ex_imm), .id_ex_ctrl_reg_write(c_rw), .id_ex_ctrl_mem_read(c_mr),
        .id_ex_ctrl_mem_write(c_mw), .id_ex_ctrl_mem_to_reg(c_m2r), .id_ex_ctrl_alu_src(c_as),
        .id_ex_ctrl_branch(c_br), .id_ex_alu_op(id_ex_alu_op),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .stall(stall)
    );

    assign got = '{valid: id_ex_valid, pc: id_ex_pc, rs1: id_ex_rs1, rs2: id_ex_rs2,
                   u1: id_ex_uses_rs1, u2: id_ex_uses_rs2, rd: id_ex_rd,
                   d1: id_ex_rs1_data, d2: id_ex_rs2_data, imm: id_ex_imm,
                   ctrl: {c_rw, c_mr, c_mw, c_m2r, c_as, c_br}, alu: id_ex_alu_op};

    task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic u1, input logic u2,
                             input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [5:0] ctrl, input logic [3:0] alu);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1;
        id_uses_rs2 = u2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = pc ^ 32'h0000_0F0F; id_ctrl = ctrl; id_alu_op = alu;
    endtask

    // One pipeline cycle: check stall, push expectation, clock, pop and compare.
    task automatic step(input string name);
        logic hz;
        logic exp_stall;
        exp_t n;
        exp_t e;
        #1;
        hz = id_valid && mdl.valid && mdl.ctrl[4] && (mdl.rd != 5'd0) &&
             ((id_uses_rs1 && mdl.rd == id_rs1) || (id_uses_rs2 && mdl.rd == id_rs2));
        exp_stall = hz && !ex_flush;
        checks++;
        if (stall !== exp_stall) begin
            failures++;
            $display("FAIL %s stall: got=%b exp=%b", name, stall, exp_stall);
        end
        n = '0;
        if (id_valid && !ex_flush && !hz) begin
            n.valid = 1'b1; n.pc = id_pc; n.rs1 = id_rs1; n.rs2 = id_rs2;
            n.u1 = id_uses_rs1; n.u2 = id_uses_rs2; n.rd = id_rd; n.imm = id_imm;
            n.ctrl = id_ctrl; n.alu = id_alu_op;
            n.d1 = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
            n.d2 = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
        end
        sb_q.push_back(n);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        mdl = e;
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s regs: got=%h exp=%h", name, got, e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mdl = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mdl = '0;
        set_instr(1'b1, $urandom, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom),
                  $urandom, $urandom, C_LW, 4'($urandom));
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = $urandom;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got !== exp_t'(0) || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: got=%h stall=%b exp=0", got, stall);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (got !== exp_t'(0) || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got=%h stall=%b exp=0", got, stall);
        end
        wb_reg_write = 1'b0;
        @(posedge clk);
        #1;
        mdl = got.valid ? got : '0;
        set_instr(1'b0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 6'd0, 4'd0);
        step("reset_idle");
    endtask

    task automatic test_pass_through();
        set_instr(1'b1, 32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 32'h11, 32'h22, C_ADD, 4'd3);
        step("pass_through");
        set_instr(1'b0, 32'h104, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 32'h11, 32'h22, C_LW, 4'd1);
        step("invalid_decode");
    endtask

    task automatic test_load_use();
        set_instr(1'b1, 32'h200, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 32'h40, 32'd0, C_LW, 4'd0);
        step("lu_load");
        set_instr(1'b1, 32'h204, 5'd7, 5'd8, 1'b1, 1'b1, 5'd9, 32'h1, 32'h2, C_ADD, 4'd0);
        step("lu_stall");
        step("lu_resume");
    endtask

    task automatic test_false_positive();
        set_instr(1'b1, 32'h300, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 32'd0, C_LW, 4'd0);
        step("fp_load_x0");
        set_instr(1'b1, 32'h304, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 32'h1, 32'h2, C_ADD, 4'd0);
        step("fp_use_x0");
        set_instr(1'b1, 32'h308, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 32'h0, 32'd0, C_LW, 4'd0);
        step("fp_load_x7");
        set_instr(1'b1, 32'h30C, 5'd3, 5'd7, 1'b1, 1'b0, 5'd9, 32'h5, 32'h6, C_ADD, 4'd2);
        step("fp_rs2_unused");
    endtask

    task automatic test_flush();
        set_instr(1'b1, 32'h400, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 32'h0, 32'd0, C_LW, 4'd0);
        step("fl_load");
        set_instr(1'b1, 32'h404, 5'd7, 5'd7, 1'b1, 1'b1, 5'd9, 32'h1, 32'h2, C_ADD, 4'd0);
        ex_flush = 1'b1;
        step("fl_with_hazard");
        set_instr(1'b1, 32'h408, 5'd4, 5'd5, 1'b1, 1'b1, 5'd10, 32'h3, 32'h4, C_ADD, 4'd4);
        step("fl_alone");
        ex_flush = 1'b0;
        step("fl_after");
    endtask

    task automatic test_wb_bypass();
        wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'hDEADBEEF;
        set_instr(1'b1, 32'h500, 5'd1, 5'd9, 1'b1, 1'b1, 5'd3, 32'h77, 32'h0, C_ADD, 4'd0);
        step("byp_rs2");
        set_instr(1'b1, 32'h504, 5'd9, 5'd2, 1'b1, 1'b1, 5'd3, 32'h0, 32'h55, C_ADD, 4'd0);
        step("byp_rs1");
        wb_rd = 5'd0; wb_data = 32'hCAFEF00D;
        set_instr(1'b1, 32'h508, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 32'h1234, 32'h5678, C_ADD, 4'd0);
        step("byp_x0");
        wb_reg_write = 1'b0; wb_rd = 5'd9;
        set_instr(1'b1, 32'h50C, 5'd9, 5'd9, 1'b1, 1'b1, 5'd3, 32'hAA, 32'hBB, C_ADD, 4'd0);
        step("byp_no_we");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            set_instr(($urandom_range(0, 9) != 0), $urandom, 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                      5'($urandom_range(0, 3)), $urandom, $urandom,
                      ($urandom_range(0, 1) != 0) ? C_LW : 6'($urandom), 4'($urandom));
            ex_flush = ($urandom_range(0, 5) == 0);
            wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
            step("random");
        end
        ex_flush = 1'b0; wb_reg_write = 1'b0;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 32'h600, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 32'h0, 32'd0, C_LW, 4'd0);
            step("pf_load");
            set_instr(1'b1, 32'h604, 5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 32'h0, 32'd0, C_ADD, 4'd0);
            step("pf_stall");
        end
        ex_flush = 1'b1;
        step("pf_flush1");
        step("pf_flush2");
        ex_flush = 1'b0;
        checks++;
        if (perf_stall_cnt !== 32'd3 || perf_flush_cnt !== 32'd2) begin
            failures++;
            $display("FAIL perf_counts: got=%0d/%0d exp=3/2", perf_stall_cnt, perf_flush_cnt);
        end
        force dut.perf_flush_cnt_r = 32'hFFFF_FFFF;
        #1 release dut.perf_flush_cnt_r;
        ex_flush = 1'b1;
        step("pf_wrap");
        ex_flush = 1'b0;
        checks++;
        if (perf_flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_wrap: got=%h exp=0", perf_flush_cnt);
        end
    endtask
`endif

    initial begin
        mdl = '0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_false_positive();
        test_flush();
        test_wb_bypass();
        test_back_to_back();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        do_reset();
        #1;
        checks++;
        if (got !== exp_t'(0)) begin
            failures++;
            $display("FAIL mid_run_reset: got=%h exp=0", got);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
